// File: rtl/pic_seq_if.sv
// Bundle between the PIC16C57 core datapath and its instruction-cycle sequencer.
//   master : the core. It drives the per-instruction requests and receives the
//            phase, enables and status.
//   slave  : the sequencer. It receives the requests and drives the phase,
//            enables and status.
// Requests : branch_taken, wb_req, sleep_req (sampled in Q4), wake (level).
// Outputs  : q (one-hot phase), pc_inc_en, pc_load_en, f_rd_en, alu_en, wb_en,
//            ir_en, exec_valid, sleeping, cycle_cnt[CNT_W-1:0].
interface pic_seq_if #(
    parameter int CNT_W = 16
);
    logic             branch_taken;
    logic             wb_req;
    logic             sleep_req;
    logic             wake;
    logic [3:0]       q;
    logic             pc_inc_en;
    logic             pc_load_en;
    logic             f_rd_en;
    logic             alu_en;
    logic             wb_en;
    logic             ir_en;
    logic             exec_valid;
    logic             sleeping;
    logic [CNT_W-1:0] cycle_cnt;

    modport master (
        output branch_taken, wb_req, sleep_req, wake,
        input  q, pc_inc_en, pc_load_en, f_rd_en, alu_en, wb_en, ir_en,
               exec_valid, sleeping, cycle_cnt
    );

    modport slave (
        input  branch_taken, wb_req, sleep_req, wake,
        output q, pc_inc_en, pc_load_en, f_rd_en, alu_en, wb_en, ir_en,
               exec_valid, sleeping, cycle_cnt
    );
endinterface

// File: rtl/pic_cycle_sequencer.sv
// Instruction-cycle sequencer for the PIC16C57 core.
// Splits every instruction cycle into four clocks Q1..Q4, issues one-clock
// enables to the core registers, flushes the prefetched instruction after a
// taken branch, refills the pipeline after reset and wake, and holds the core
// in SLEEP until woken.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous, active-high reset
//   bus : pic_seq_if.slave (requests in; phase, enables, status out)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_RUN   | q rotates Q1->Q2->Q3->Q4 each clock; enables active
// ST_SLEEP | q held at Q1, all enables 0, cycle counter frozen; wake exits
module pic_cycle_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    pic_seq_if.slave    bus
);
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_SLEEP = 1'b1
    } st_e;

    st_e              st_q, st_d;
    logic [3:0]       q_q, q_d;
    logic             exec_valid_q, exec_valid_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;

    logic pc_inc_en, pc_load_en, f_rd_en, alu_en, wb_en, ir_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q         <= ST_RUN;
            q_q          <= 4'b0001;
            exec_valid_q <= 1'b0;
            cycle_cnt_q  <= '0;
        end else begin
            st_q         <= st_d;
            q_q          <= q_d;
            exec_valid_q <= exec_valid_d;
            cycle_cnt_q  <= cycle_cnt_d;
        end
    end

    always_comb begin
        st_d         = st_q;
        q_d          = q_q;
        exec_valid_d = exec_valid_q;
        cycle_cnt_d  = cycle_cnt_q;
        case (st_q)
            ST_RUN: begin
                q_d = {q_q[2:0], q_q[3]};
                if (q_q[3]) begin
                    cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
                    // Requests only count when the cycle executed a real
                    // instruction; sleep outranks a simultaneous branch.
                    if (exec_valid_q && bus.sleep_req) begin
                        st_d         = ST_SLEEP;
                        q_d          = 4'b0001;
                        exec_valid_d = 1'b0;
                    end else if (exec_valid_q && bus.branch_taken) begin
                        exec_valid_d = 1'b0;
                    end else begin
                        exec_valid_d = 1'b1;
                    end
                end
            end
            ST_SLEEP: begin
                q_d          = 4'b0001;
                exec_valid_d = 1'b0;
                if (bus.wake) begin
                    st_d = ST_RUN;
                end
            end
            default: begin
                st_d = ST_RUN;
                q_d  = 4'b0001;
            end
        endcase
    end

    // Enables are gated by rst combinationally so nothing fires while the
    // core is held in reset, even though q already reads Q1.
    always_comb begin
        logic active;
        active     = !rst && (st_q == ST_RUN);
        pc_inc_en  = active && q_q[0];
        f_rd_en    = active && q_q[1] && exec_valid_q;
        alu_en     = active && q_q[2] && exec_valid_q;
        wb_en      = active && q_q[3] && exec_valid_q && bus.wb_req
                     && !bus.sleep_req;
        pc_load_en = active && q_q[3] && exec_valid_q && bus.branch_taken
                     && !bus.sleep_req;
        ir_en      = active && q_q[3];
    end

    assign bus.q          = q_q;
    assign bus.exec_valid = exec_valid_q;
    assign bus.cycle_cnt  = cycle_cnt_q;
    assign bus.sleeping   = (st_q == ST_SLEEP);
    assign bus.pc_inc_en  = pc_inc_en;
    assign bus.pc_load_en = pc_load_en;
    assign bus.f_rd_en    = f_rd_en;
    assign bus.alu_en     = alu_en;
    assign bus.wb_en      = wb_en;
    assign bus.ir_en      = ir_en;
endmodule

// File: tb/tb_pic_cycle_sequencer.sv
// Directed bench for pic_cycle_sequencer, built with a 4-bit cycle counter so
// the wrap is reachable. Inputs change 2 time units after a rising edge and
// outputs are sampled 1 unit later, well clear of both edges.
module tb_pic_cycle_sequencer;
    localparam int CNT_W = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    pic_seq_if #(.CNT_W(CNT_W)) bus ();

    pic_cycle_sequencer #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic next_clk();
        @(posedge clk);
        #2;
    endtask

    // Full check of one RUN clock. pc_inc_en and ir_en follow the phase,
    // f_rd_en/alu_en follow exec_valid, wb_en/pc_load_en are given explicitly.
    task automatic check_clk(input string tag, input logic [3:0] eq, input bit ev,
                             input int cnt, input bit ewb, input bit eld);
        chk({tag, " q"},          32'(bus.q),          32'(eq));
        chk({tag, " exec_valid"}, 32'(bus.exec_valid), 32'(ev));
        chk({tag, " cycle_cnt"},  32'(bus.cycle_cnt),  32'(cnt));
        chk({tag, " sleeping"},   32'(bus.sleeping),   32'(0));
        chk({tag, " pc_inc_en"},  32'(bus.pc_inc_en),  32'(eq == 4'b0001));
        chk({tag, " f_rd_en"},    32'(bus.f_rd_en),    32'(eq == 4'b0010 && ev));
        chk({tag, " alu_en"},     32'(bus.alu_en),     32'(eq == 4'b0100 && ev));
        chk({tag, " ir_en"},      32'(bus.ir_en),      32'(eq == 4'b1000));
        chk({tag, " wb_en"},      32'(bus.wb_en),      32'(ewb));
        chk({tag, " pc_load_en"}, 32'(bus.pc_load_en), 32'(eld));
    endtask

    // Called at Q1 of a cycle; leaves the bench at Q1 of the following cycle.
    task automatic run_cycle(input string tag, input bit ev, input int cnt,
                             input bit wb, input bit br, input bit sl,
                             input bit ewb, input bit eld);
        bus.wb_req       = wb;
        bus.branch_taken = br;
        bus.sleep_req    = sl;
        #1;
        for (int p = 0; p < 4; p++) begin
            check_clk($sformatf("%s Q%0d", tag, p + 1), 4'(1 << p), ev, cnt,
                      (p == 3) ? ewb : 1'b0, (p == 3) ? eld : 1'b0);
            next_clk();
        end
    endtask

    task automatic check_all_en_zero(input string tag);
        chk({tag, " pc_inc_en"},  32'(bus.pc_inc_en),  32'(0));
        chk({tag, " f_rd_en"},    32'(bus.f_rd_en),    32'(0));
        chk({tag, " alu_en"},     32'(bus.alu_en),     32'(0));
        chk({tag, " wb_en"},      32'(bus.wb_en),      32'(0));
        chk({tag, " pc_load_en"}, 32'(bus.pc_load_en), 32'(0));
        chk({tag, " ir_en"},      32'(bus.ir_en),      32'(0));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.branch_taken = 1'b0;
        bus.wb_req       = 1'b0;
        bus.sleep_req    = 1'b0;
        bus.wake         = 1'b0;

        // Reset held for two clocks; enables must be silent while rst=1.
        repeat (2) @(posedge clk);
        #2;
        chk("rst q",          32'(bus.q),          32'h1);
        chk("rst exec_valid", 32'(bus.exec_valid), 32'h0);
        chk("rst cycle_cnt",  32'(bus.cycle_cnt),  32'h0);
        chk("rst sleeping",   32'(bus.sleeping),   32'h0);
        check_all_en_zero("rst");
        rst = 1'b0;

        // Refill cycle: requests present but ignored because exec_valid=0.
        run_cycle("c1 refill", 1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        // First executing cycle (clock 5): write-back and taken branch.
        run_cycle("c2 branch", 1'b1, 1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        // Flushed cycle: wb_req still high, but no write and no operand path.
        run_cycle("c3 flush",  1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_cycle("c4 exec",   1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // SLEEP together with a branch: sleep wins, branch and write dropped.
        run_cycle("c5 sleep",  1'b1, 4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        bus.wb_req       = 1'b0;
        bus.branch_taken = 1'b0;
        bus.sleep_req    = 1'b0;
        #1;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("sleep%0d sleeping", i),   32'(bus.sleeping),   32'h1);
            chk($sformatf("sleep%0d q", i),          32'(bus.q),          32'h1);
            chk($sformatf("sleep%0d cycle_cnt", i),  32'(bus.cycle_cnt),  32'h5);
            chk($sformatf("sleep%0d exec_valid", i), 32'(bus.exec_valid), 32'h0);
            check_all_en_zero($sformatf("sleep%0d", i));
            if (i == 9) bus.wake = 1'b1;
            next_clk();
        end

        // Woken: refill with wake still high (ignored in RUN), then execute.
        run_cycle("c6 wake refill", 1'b0, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.wake = 1'b0;
        run_cycle("c7 exec", 1'b1, 6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of an executing cycle at Q3 with cycle_cnt=7.
        next_clk();
        next_clk();
        #1;
        chk("pre-rst q",          32'(bus.q),          32'h4);
        chk("pre-rst exec_valid", 32'(bus.exec_valid), 32'h1);
        chk("pre-rst cycle_cnt",  32'(bus.cycle_cnt),  32'h7);
        chk("pre-rst alu_en",     32'(bus.alu_en),     32'h1);
        rst = 1'b1;
        #1;
        check_all_en_zero("mid-rst");
        next_clk();
        chk("post-rst q",          32'(bus.q),          32'h1);
        chk("post-rst exec_valid", 32'(bus.exec_valid), 32'h0);
        chk("post-rst cycle_cnt",  32'(bus.cycle_cnt),  32'h0);
        check_all_en_zero("post-rst");
        rst = 1'b0;

        // 4-bit counter: 0..15, wrap to 0, then 1.
        for (int i = 0; i < 18; i++) begin
            run_cycle($sformatf("wrap%0d", i), i > 0, i % 16,
                      1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
